// File: rtl/cipher_pkg.sv
// Shared types for the cipher stream packer: character width,
// FIFO entry layout and frame FSM states.
package cipher_pkg;

    localparam int CHAR_W = 8;

    typedef struct packed {
        logic              last;
        logic [CHAR_W-1:0] ch;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic {
        IDLE,
        FILL
    } frame_state_t;

endpackage

// File: rtl/cipher_sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through read, with a port
// that ORs a mask into the most recently written entry.
module cipher_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    input  logic                     tail_en,
    input  logic [WIDTH-1:0]         tail_mask,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    tail_addr;
    logic             wr_en;
    logic             rd_en;

    // Wrap bits differ and index bits match: every slot is occupied.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign rd_en     = pop & ~empty;
    assign wr_en     = push & (~full | rd_en);
    assign tail_addr = wr_ptr[AW-1:0] - 1'b1;
    assign dout      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
        if (tail_en) mem[tail_addr] <= mem[tail_addr] | tail_mask;
    end

endmodule

// File: rtl/cipher_stream_packer.sv
// Buffers the cipher character stream into MSG_LEN frames for a byte consumer.
// Define CIPHER_PASSTHRU_EN to forward out-of-table characters raw.
module cipher_stream_packer
    import cipher_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MSG_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_stb,
    input  logic                   in_valid,
    input  logic [CHAR_W-1:0]      in_char,
    input  logic [CHAR_W-1:0]      raw_char,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHAR_W-1:0]      out_data,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    frame_state_t      state;
    logic [7:0]        frame_cnt;
    logic              push_req;
    logic [CHAR_W-1:0] push_ch;
    logic              push_ok;
    logic              pop;
    logic              frame_end;
    logic              tail_en;
    logic              fifo_full;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head;
    entry_t            tail_mask;

`ifdef CIPHER_PASSTHRU_EN
    assign push_req = in_stb;
    assign push_ch  = in_valid ? in_char : raw_char;
    assign drop_cnt = '0;
`else
    logic unused_raw;

    assign push_req   = in_stb & in_valid;
    assign push_ch    = in_char;
    assign unused_raw = ^raw_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (in_stb && !in_valid && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    assign pop        = ~fifo_empty & out_ready;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign frame_end  = (frame_cnt == LAST_IDX) | flush;
    assign push_entry = '{last: frame_end, ch: push_ch};
    assign tail_mask  = '{last: 1'b1, ch: '0};
    // A bare flush closes the frame by tagging the entry already written.
    assign tail_en    = flush & ~push_ok & (state == FILL);

    cipher_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .din       (push_entry),
        .pop       (pop),
        .dout      (head),
        .tail_en   (tail_en),
        .tail_mask (tail_mask),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
        end else if (push_ok) begin
            if (frame_end) begin
                state     <= IDLE;
                frame_cnt <= '0;
            end else begin
                state     <= FILL;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end else if (flush && state == FILL) begin
            state     <= IDLE;
            frame_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? '0 : head.ch;
    assign out_last  = fifo_empty ? 1'b0 : head.last;

endmodule
